// File: rtl/phy_serdes_lanes.sv
// Lane serialiser/deserialiser on a single bit clock: N_LANES words per frame, COM preamble,
// IDL fill for invalid slots, and a COM-aligned receiver that re-tags words by lane.
module phy_serdes_lanes #(
  parameter int unsigned N_LANES     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter logic [DATA_W-1:0] COM   = 8'hBC,
  parameter logic [DATA_W-1:0] IDL   = 8'h7C,
  parameter int unsigned SYNC_FRAMES = 2,
  parameter int unsigned ALIGN_CNT   = 4,
  localparam int unsigned LANE_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                        clk_32f,
  input  logic                        reset,
  input  logic [N_LANES*DATA_W-1:0]   data_in,
  input  logic [N_LANES-1:0]          valid_in,
  output logic                        frame_req,
  output logic                        data_out,
  input  logic                        serial_in,
  output logic [DATA_W-1:0]           data_rx,
  output logic                        valid_rx,
  output logic [LANE_W-1:0]           lane_rx,
  output logic                        active
);

  localparam int unsigned BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned FRAME_W = $clog2(SYNC_FRAMES + 1);
  localparam int unsigned ALIGN_W = $clog2(ALIGN_CNT + 1);

  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [LANE_W-1:0]  LANE_LAST  = LANE_W'(N_LANES - 1);
  localparam logic [FRAME_W-1:0] SYNC_LAST  = FRAME_W'(SYNC_FRAMES - 1);
  localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(ALIGN_CNT - 1);

  // The receiver must be able to lock inside the preamble.
  if (SYNC_FRAMES * N_LANES < ALIGN_CNT + 1) begin : gen_cfg_check
    $error("phy_serdes_lanes: SYNC_FRAMES*N_LANES must be at least ALIGN_CNT+1");
  end

  typedef enum logic {TxSync, TxData} tx_state_e;
  typedef enum logic [1:0] {RxSearch, RxLock, RxActive} rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [LANE_W-1:0]  laneslot_q, laneslot_d, next_lane;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d, tx_word;
  logic [DATA_W-1:0]  buf_q [N_LANES];
  logic [N_LANES-1:0] buf_vld_q;
  logic               bit_last, lane_last, frame_end, sync_last;

  logic [DATA_W-1:0]  rx_sr_q, rx_sr_d;
  logic [BIT_W-1:0]   rx_phase_q, rx_phase_d;
  logic [ALIGN_W-1:0] align_cnt_q, align_cnt_d;
  logic [LANE_W-1:0]  rx_lane_q, rx_lane_d;
  logic [DATA_W-1:0]  data_rx_q, data_rx_d;
  logic [LANE_W-1:0]  lane_rx_q, lane_rx_d;
  logic               valid_rx_q, valid_rx_d;
  logic               active_q, active_d;
  logic               is_com, is_idl, phase_end;

  assign bit_last  = (bitcnt_q == BIT_LAST);
  assign lane_last = (laneslot_q == LANE_LAST);
  assign frame_end = bit_last && lane_last;
  assign sync_last = (frame_cnt_q == SYNC_LAST);

  assign is_com    = (rx_sr_q == COM);
  assign is_idl    = (rx_sr_q == IDL);
  assign phase_end = (rx_phase_q == BIT_LAST);

  // State registers
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      tx_state_q <= TxSync;
      rx_state_q <= RxSearch;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    tx_state_d = tx_state_q;
    if (tx_state_q == TxSync && frame_end && sync_last) tx_state_d = TxData;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RxSearch: if (is_com) rx_state_d = RxLock;
      RxLock: begin
        if (phase_end) begin
          if (!is_com)                        rx_state_d = RxSearch;
          else if (align_cnt_q == ALIGN_LAST) rx_state_d = RxActive;
        end
      end
      RxActive: rx_state_d = RxActive;
      default:  rx_state_d = RxSearch;
    endcase
  end

  // Outputs
  always_comb begin
    frame_req = frame_end && (tx_state_q == TxData || sync_last);
    data_out  = tx_sr_q[DATA_W-1];
    data_rx   = data_rx_q;
    lane_rx   = lane_rx_q;
    valid_rx  = valid_rx_q;
    active    = active_q;
  end

  // TX datapath
  always_comb begin
    bitcnt_d   = bit_last ? '0 : bitcnt_q + BIT_W'(1);
    laneslot_d = laneslot_q;
    if (bit_last) laneslot_d = lane_last ? '0 : laneslot_q + LANE_W'(1);
    frame_cnt_d = frame_cnt_q;
    if (tx_state_q == TxSync && frame_end && !sync_last) frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    next_lane = laneslot_q + LANE_W'(1);
    // Lane 0 of a new data frame comes straight from the inputs being captured this edge.
    if (frame_req)                tx_word = valid_in[0] ? data_in[DATA_W-1:0] : IDL;
    else if (tx_state_q == TxData) tx_word = buf_vld_q[next_lane] ? buf_q[next_lane] : IDL;
    else                          tx_word = COM;
    tx_sr_d = bit_last ? tx_word : {tx_sr_q[DATA_W-2:0], 1'b0};
  end

  // RX datapath
  always_comb begin
    rx_sr_d     = {rx_sr_q[DATA_W-2:0], serial_in};
    rx_phase_d  = (rx_state_q == RxSearch || phase_end) ? '0 : rx_phase_q + BIT_W'(1);
    align_cnt_d = align_cnt_q;
    rx_lane_d   = rx_lane_q;
    data_rx_d   = data_rx_q;
    lane_rx_d   = lane_rx_q;
    valid_rx_d  = 1'b0;
    active_d    = active_q || (rx_state_d == RxActive);
    if (rx_state_q == RxSearch) begin
      align_cnt_d = is_com ? ALIGN_W'(1) : '0;
    end else if (rx_state_q == RxLock && phase_end) begin
      align_cnt_d = is_com ? align_cnt_q + ALIGN_W'(1) : '0;
    end else if (rx_state_q == RxActive && phase_end) begin
      if (is_com) begin
        rx_lane_d = '0;
      end else begin
        rx_lane_d = (rx_lane_q == LANE_LAST) ? '0 : rx_lane_q + LANE_W'(1);
        if (!is_idl) begin
          valid_rx_d = 1'b1;
          data_rx_d  = rx_sr_q;
          lane_rx_d  = rx_lane_q;
        end
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      bitcnt_q    <= '0;
      laneslot_q  <= '0;
      frame_cnt_q <= '0;
      tx_sr_q     <= COM;
      buf_vld_q   <= '0;
      for (int k = 0; k < int'(N_LANES); k++) buf_q[k] <= '0;
      rx_sr_q     <= '0;
      rx_phase_q  <= '0;
      align_cnt_q <= '0;
      rx_lane_q   <= '0;
      data_rx_q   <= '0;
      lane_rx_q   <= '0;
      valid_rx_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      bitcnt_q    <= bitcnt_d;
      laneslot_q  <= laneslot_d;
      frame_cnt_q <= frame_cnt_d;
      tx_sr_q     <= tx_sr_d;
      if (frame_req) begin
        buf_vld_q <= valid_in;
        for (int k = 0; k < int'(N_LANES); k++) buf_q[k] <= data_in[k*DATA_W +: DATA_W];
      end
      rx_sr_q     <= rx_sr_d;
      rx_phase_q  <= rx_phase_d;
      align_cnt_q <= align_cnt_d;
      rx_lane_q   <= rx_lane_d;
      data_rx_q   <= data_rx_d;
      lane_rx_q   <= lane_rx_d;
      valid_rx_q  <= valid_rx_d;
      active_q    <= active_d;
    end
  end

endmodule

// File: tb/tb_phy_serdes_lanes.sv
// Bench for phy_serdes_lanes: loopback frame vectors with an RX scoreboard, alignment with a
// bit offset, mid-run reset, and a second 8-lane/10-bit instance.
module tb_phy_serdes_lanes;

  localparam int NV = 6;
  localparam logic [7:0] IDL8 = 8'h7C;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic        frame_req, data_out, serial_in;
  logic [7:0]  data_rx;
  logic        valid_rx;
  logic [1:0]  lane_rx;
  logic        active;
  logic        loop_en, drv_bit;

  logic [79:0] data_in2;
  logic [7:0]  valid_in2;
  logic        frame_req2, data_out2;
  logic [9:0]  data_rx2;
  logic        valid_rx2;
  logic [2:0]  lane_rx2;
  logic        active2;

  always #5 clk_32f = ~clk_32f;
  assign serial_in = loop_en ? data_out : drv_bit;

  phy_serdes_lanes dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .frame_req(frame_req), .data_out(data_out), .serial_in(serial_in), .data_rx(data_rx),
    .valid_rx(valid_rx), .lane_rx(lane_rx), .active(active)
  );

  phy_serdes_lanes #(
    .N_LANES(8), .DATA_W(10), .COM(10'h17C), .IDL(10'h0FC)
  ) dut2 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in2), .valid_in(valid_in2),
    .frame_req(frame_req2), .data_out(data_out2), .serial_in(data_out2), .data_rx(data_rx2),
    .valid_rx(valid_rx2), .lane_rx(lane_rx2), .active(active2)
  );

  typedef struct {
    logic [31:0]     data;
    logic [3:0]      valid;
    logic [3:0][7:0] wire_w;  // expected word on the wire per lane slot
  } vec_t;

  vec_t        vecs [NV];
  logic [9:0]  q1 [$];
  logic [12:0] q2 [$];
  int total, bad, cyc, cur_idx, first_p1, first_p2, cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] d, input logic [3:0] v,
                         input logic [31:0] w);
    vecs[i].data   = d;
    vecs[i].valid  = v;
    vecs[i].wire_w = w;
  endtask

  task automatic apply(input int i);
    cur_idx  = i;
    data_in  = vecs[i].data;
    valid_in = vecs[i].valid;
  endtask

  // One cycle: sample at the falling edge, push expectations on capture, pop on valid_rx.
  task automatic tick();
    logic [9:0]  e1;
    logic [12:0] e2;
    @(negedge clk_32f);
    cyc++;
    if (frame_req)
      for (int k = 0; k < 4; k++)
        if (vecs[cur_idx].wire_w[k] != IDL8) q1.push_back({2'(k), vecs[cur_idx].wire_w[k]});
    if (frame_req2)
      for (int k = 0; k < 8; k++) q2.push_back({3'(k), 10'h201 + 10'(k)});
    if (valid_rx) begin
      if (first_p1 < 0) first_p1 = cyc;
      check("rx1_expected_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("rx1_lane_word", {22'b0, lane_rx, data_rx}, {22'b0, e1});
      end
    end
    if (valid_rx2) begin
      if (first_p2 < 0) first_p2 = cyc;
      cnt2++;
      check("rx2_expected_pending", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        check("rx2_lane_word", {19'b0, lane_rx2, data_rx2}, {19'b0, e2});
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk_32f);
    reset    = 1'b1;
    cyc      = 0;
    first_p1 = -1;
    first_p2 = -1;
    cnt2     = 0;
    q1.delete();
    q2.delete();
  endtask

  // Starts on cycle 0 right after reset release, loopback enabled.
  task automatic session();
    logic [7:0] sr;
    int first_req, first_act, n;
    check("rst_data_out", 32'(data_out), 32'd1);
    check("rst_frame_req", 32'(frame_req), 32'd0);
    check("rst_valid_rx", 32'(valid_rx), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_data_rx", 32'(data_rx), 32'd0);
    check("rst_lane_rx", 32'(lane_rx), 32'd0);
    check("rst2_data_out", 32'(data_out2), 32'd0);
    check("rst2_active", 32'(active2), 32'd0);
    apply(0);
    sr = {7'b0, data_out};
    first_req = -1;
    first_act = -1;
    for (int c = 1; c < 64; c++) begin
      tick();
      sr = {sr[6:0], data_out};
      if (frame_req && first_req < 0) first_req = cyc;
      if (active && first_act < 0) first_act = cyc;
      if (c % 8 == 7) check("preamble_word", 32'(sr), 32'hBC);
    end
    check("first_frame_req", first_req, 63);
    check("first_active", first_act, 33);
    for (int i = 0; i < NV - 1; i++) begin
      n = 0;
      while (!frame_req && n < 64) begin
        tick();
        n++;
      end
      check("frame_req_period", n, 0);
      for (int j = 1; j <= 32; j++) begin
        tick();
        sr = {sr[6:0], data_out};
        if (j == 1) apply(i + 1);
        if (j % 8 == 0) check("wire_word", 32'(sr), 32'(vecs[i].wire_w[j/8-1]));
      end
    end
    repeat (30) tick();
    check("rx1_drained", q1.size(), 0);
    check("first_pulse1", first_p1, 73);
    check("first_pulse2", first_p2, 171);
    check("rx2_count", 32'(cnt2 >= 8), 32'd1);
  endtask

  initial begin
    logic [58:0] seq;
    int first_act;
    total    = 0;
    bad      = 0;
    cyc      = 0;
    first_p1 = -1;
    first_p2 = -1;
    cnt2     = 0;
    loop_en  = 1'b1;
    drv_bit  = 1'b0;
    reset    = 1'b0;
    for (int k = 0; k < 8; k++) data_in2[k*10 +: 10] = 10'h201 + 10'(k);
    valid_in2 = 8'hFF;

    set_vec(0, 32'hA3A2A1A0, 4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    set_vec(1, 32'hA3A2A1A0, 4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    set_vec(2, 32'hD3D2D1D0, 4'b0101, {8'h7C, 8'hD2, 8'h7C, 8'hD0});
    set_vec(3, 32'h11223344, 4'b1010, {8'h11, 8'h7C, 8'h33, 8'h7C});
    set_vec(4, 32'h01020304, 4'b1111, {8'h01, 8'h02, 8'h03, 8'h04});
    set_vec(5, 32'h5A5A5A5A, 4'b0000, {8'h7C, 8'h7C, 8'h7C, 8'h7C});
    apply(NV - 1);

    do_reset(5);
    session();

    // Offset alignment: 3 stray bits, COM, COM, 0x55, then four COMs.
    loop_en = 1'b0;
    drv_bit = 1'b0;
    apply(NV - 1);
    do_reset(3);
    seq = {3'($urandom_range(0, 7)), 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    drv_bit   = seq[58];
    first_act = -1;
    for (int i = 1; i < 63; i++) begin
      tick();
      if (active && first_act < 0) first_act = cyc;
      drv_bit = (i < 59) ? seq[58-i] : 1'b0;
    end
    check("align_after_offset", first_act, 60);
    check("active_held", 32'(active), 32'd1);

    // Single-cycle reset in the middle of data traffic.
    loop_en = 1'b1;
    do_reset(5);
    apply(0);
    repeat (100) tick();
    do_reset(1);
    session();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
